in_line_controller: RTL and testbench
=====================================

// Module: in_line_controller
// PURPOSE
//  Line-buffer front end of the conv accelerator. Takes a raster-order 32x32 8-bit pixel stream and
//  stores it in a 6-row circular buffer. Presents every valid 5x5 window (28x28 = 784, no padding)
//  to the downstream convolution engine under a valid/ready handshake.
// PARAMETERS
//  IMG_W   32  image width in pixels
//  IMG_H   32  image height in rows
//  K       5   window size (output grid (IMG_W-K+1) x (IMG_H-K+1))
//  NBUF    6   line-buffer rows (K+1, one row prefetched during convolution)
//  DATA_W  8   pixel width
// PORTS
//  clk                 in   1   rising-edge clock
//  reset_n             in   1   asynchronous active-low reset
//  i_start             in   1   start a frame; sampled only in IDLE/FINISH
//  o_done              out  1   frame complete; held high in FINISH
//  pixel_in_valid      in   1   pixel_in valid
//  pixel_in            in   8   pixel, raster order
//  pixel_ready         out  1   buffer can accept a pixel this cycle
//  o_conv_valid        out  1   window_* holds a valid window
//  i_conv_ready        in   1   consumer accepts window
//  o_conv_row_start    out  1   high with first window of an output row (col 0)
//  o_conv_row_end      out  1   high with last window of an output row (col 27)
//  window_r_c          out  8   signed, r,c in 0..4; 25 ports; r=row (top=0), c=col (left=0)
//  o_read_base_ptr     out  3   buffer slot holding window row 0 (0..5)
//  o_write_ptr         out  3   buffer slot being written (0..5)
//  o_current_state     out  4   FSM state code
//  o_window_col        out  5   current output column 0..27
//  o_output_row_cnt    out  5   current output row 0..27
// BEHAVIOUR
//  Reset (async, any time, mid-frame included): state IDLE. Clear all pointers, counters and o_done.
//   All outputs are 0; buffer contents need not be cleared.
//  Write side: a pixel is accepted on posedge when pixel_in_valid && pixel_ready. It is stored at
//   buf[write_ptr][wr_col]. wr_col wraps 31->0, and write_ptr advances mod 6; rows_written++.
//  pixel_ready = state in {LOAD_INIT,CONV_ROW,ROLL} && rows_written<32 && rows_written<out_row+6.
//   The slot in use by the current window is never overwritten.
//  Window: window_r_c = buf[(read_base_ptr+r)%6][window_col+c], combinational from registers.
//   Bits are reinterpreted as signed; there is no conversion.
//  FSM codes: IDLE=0, LOAD_INIT=1, CONV_ROW=2, ROLL=3, FINISH=4.
//   IDLE: i_start -> LOAD_INIT.
//   LOAD_INIT: accept pixels; once rows_written>=5 -> CONV_ROW with window_col=0, row=0.
//   CONV_ROW: o_conv_valid=1. On o_conv_valid&&i_conv_ready, window_col++. Accepting at col 27 -> ROLL.
//    With i_conv_ready=0, window and col hold and o_conv_valid stays 1.
//   ROLL: if out_row==27 -> FINISH. Otherwise wait until rows_written>=out_row+6.
//    Then read_base_ptr=(read_base_ptr+1)%6, out_row++, window_col=0 -> CONV_ROW.
//   FINISH: o_done=1, pixel_ready=0. i_start clears counters and pointers -> LOAD_INIT.
//  i_start outside IDLE/FINISH is ignored. Pixels offered while pixel_ready=0 are not consumed.
//  First window appears 1 cycle after the 160th pixel is accepted. Throughput is 1 window/cycle
//   within a row, plus >=1 ROLL cycle between rows.
// CONFIGURATION
//  INLC_DEBUG_EN: when defined, o_read_base_ptr/o_write_ptr/o_current_state/o_window_col/
//   o_output_row_cnt reflect internal state as above. When undefined, all five are tied to 0.
//   Functional behaviour is otherwise identical.
// TESTING
//  Image img[i]=i%256, diagonal img[33k]=EE, img[31]=BB, img[992]=CC, img[1023]=DD.
//  1 Reset, start, stream 1024 px, i_conv_ready=1 -> exactly 784 o_conv_valid cycles, then o_done=1.
//  2 Window 1: row0 = EE 01 02 03 04, center 2_2=EE. Window 2: center=43.
//    Window k center = img[((k-1)/28+2)*32+(k-1)%28+2].
//  3 i_conv_ready=0 for 10 cycles mid-row -> window_* and o_window_col frozen. No window lost/duplicated.
//  4 Row boundaries: row_start with col 0, row_end with col 27, 28 of each.
//    read_base_ptr walks 0..5 and wraps to 0 at output row 6.
//  5 Withhold pixels after row 5 -> pixel_ready stays 1 and CONV_ROW for row 0 completes.
//    ROLL then stalls until row 5 is fully written.
//  6 Assert reset_n=0 mid-frame -> all outputs 0, IDLE. A new start reproduces test 1.

Source files
------------

// File: rtl/in_line_controller.sv
// 5x5 sliding-window line buffer: 32x32 raster pixels in, one 5x5 window per cycle out (valid/ready).
// Six-row circular buffer, so the row after the current window prefetches while the window is consumed. Optional INLC_DEBUG_EN exposes internal pointers.
module in_line_controller #(
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int K      = 5,
   parameter int NBUF   = 6,
   parameter int DATA_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_start,
   output logic                     o_done,
   input  logic                     pixel_in_valid,
   input  logic [DATA_W-1:0]        pixel_in,
   output logic                     pixel_ready,
   output logic                     o_conv_valid,
   input  logic                     i_conv_ready,
   output logic                     o_conv_row_start,
   output logic                     o_conv_row_end,
   output logic signed [DATA_W-1:0] window_0_0, window_0_1, window_0_2, window_0_3, window_0_4,
   output logic signed [DATA_W-1:0] window_1_0, window_1_1, window_1_2, window_1_3, window_1_4,
   output logic signed [DATA_W-1:0] window_2_0, window_2_1, window_2_2, window_2_3, window_2_4,
   output logic signed [DATA_W-1:0] window_3_0, window_3_1, window_3_2, window_3_3, window_3_4,
   output logic signed [DATA_W-1:0] window_4_0, window_4_1, window_4_2, window_4_3, window_4_4,
   output logic [2:0]               o_read_base_ptr,
   output logic [2:0]               o_write_ptr,
   output logic [3:0]               o_current_state,
   output logic [4:0]               o_window_col,
   output logic [4:0]               o_output_row_cnt
);
   localparam int OUT_W = IMG_W - K + 1;
   localparam int OUT_H = IMG_H - K + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H + 1);
   localparam int PW    = $clog2(NBUF);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      LOAD_INIT = 4'd1,
      CONV_ROW  = 4'd2,
      ROLL      = 4'd3,
      FINISH    = 4'd4
   } state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     write_ptr, read_base_ptr;
   logic [CW-1:0]     wr_col, window_col, out_row;
   logic [RW-1:0]     rows_written;
   logic              start_frame, col_adv, row_adv, pix_acc;
   logic [DATA_W-1:0] line_buf [NBUF][IMG_W];

   // A row may only be written once the window no longer covers its slot.
   assign pixel_ready = (state == LOAD_INIT || state == CONV_ROW || state == ROLL)
                     && (rows_written < RW'(IMG_H))
                     && (rows_written < ({1'b0, out_row} + RW'(NBUF)));
   assign pix_acc = pixel_in_valid && pixel_ready;

   always_comb begin
      state_nxt    = state;
      start_frame  = 1'b0;
      col_adv      = 1'b0;
      row_adv      = 1'b0;
      o_conv_valid = 1'b0;
      o_done       = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               start_frame = 1'b1;
               state_nxt   = LOAD_INIT;
            end
         end
         LOAD_INIT: begin
            if (rows_written >= RW'(K)) state_nxt = CONV_ROW;
         end
         CONV_ROW: begin
            o_conv_valid = 1'b1;
            if (i_conv_ready) begin
               col_adv = 1'b1;
               if (window_col == CW'(OUT_W - 1)) state_nxt = ROLL;
            end
         end
         ROLL: begin
            if (out_row == CW'(OUT_H - 1)) begin
               state_nxt = FINISH;
            end else if (rows_written >= ({1'b0, out_row} + RW'(NBUF))) begin
               row_adv   = 1'b1;
               state_nxt = CONV_ROW;
            end
         end
         FINISH: begin
            o_done = 1'b1;
            if (i_start) begin
               start_frame = 1'b1;
               state_nxt   = LOAD_INIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         write_ptr     <= '0;
         wr_col        <= '0;
         rows_written  <= '0;
         read_base_ptr <= '0;
         window_col    <= '0;
         out_row       <= '0;
      end else begin
         state <= state_nxt;
         if (start_frame) begin
            write_ptr     <= '0;
            wr_col        <= '0;
            rows_written  <= '0;
            read_base_ptr <= '0;
            window_col    <= '0;
            out_row       <= '0;
         end else begin
            if (pix_acc) begin
               if (wr_col == CW'(IMG_W - 1)) begin
                  wr_col       <= '0;
                  write_ptr    <= (write_ptr == PW'(NBUF - 1)) ? '0 : write_ptr + 1'b1;
                  rows_written <= rows_written + 1'b1;
               end else begin
                  wr_col <= wr_col + 1'b1;
               end
            end
            if (row_adv) begin
               read_base_ptr <= (read_base_ptr == PW'(NBUF - 1)) ? '0 : read_base_ptr + 1'b1;
               out_row       <= out_row + 1'b1;
               window_col    <= '0;
            end else if (col_adv) begin
               window_col <= (window_col == CW'(OUT_W - 1)) ? '0 : window_col + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pix_acc) line_buf[write_ptr][wr_col] <= pixel_in;
   end

   // Window taps are forced to zero whenever no window is being presented.
   logic [DATA_W-1:0] win [K][K];
   for (genvar r = 0; r < K; r++) begin : g_row
      logic [PW:0]   slot_sum;
      logic [PW-1:0] slot;
      assign slot_sum = {1'b0, read_base_ptr} + (PW+1)'(r);
      assign slot     = (slot_sum >= (PW+1)'(NBUF)) ? PW'(slot_sum - (PW+1)'(NBUF)) : PW'(slot_sum);
      for (genvar c = 0; c < K; c++) begin : g_col
         assign win[r][c] = o_conv_valid ? line_buf[slot][window_col + CW'(c)] : '0;
      end
   end

   assign window_0_0 = win[0][0]; assign window_0_1 = win[0][1]; assign window_0_2 = win[0][2];
   assign window_0_3 = win[0][3]; assign window_0_4 = win[0][4];
   assign window_1_0 = win[1][0]; assign window_1_1 = win[1][1]; assign window_1_2 = win[1][2];
   assign window_1_3 = win[1][3]; assign window_1_4 = win[1][4];
   assign window_2_0 = win[2][0]; assign window_2_1 = win[2][1]; assign window_2_2 = win[2][2];
   assign window_2_3 = win[2][3]; assign window_2_4 = win[2][4];
   assign window_3_0 = win[3][0]; assign window_3_1 = win[3][1]; assign window_3_2 = win[3][2];
   assign window_3_3 = win[3][3]; assign window_3_4 = win[3][4];
   assign window_4_0 = win[4][0]; assign window_4_1 = win[4][1]; assign window_4_2 = win[4][2];
   assign window_4_3 = win[4][3]; assign window_4_4 = win[4][4];

   assign o_conv_row_start = o_conv_valid && (window_col == '0);
   assign o_conv_row_end   = o_conv_valid && (window_col == CW'(OUT_W - 1));

`ifdef INLC_DEBUG_EN
   assign o_read_base_ptr  = read_base_ptr;
   assign o_write_ptr      = write_ptr;
   assign o_current_state  = state;
   assign o_window_col     = window_col;
   assign o_output_row_cnt = out_row;
`else
   assign o_read_base_ptr  = '0;
   assign o_write_ptr      = '0;
   assign o_current_state  = '0;
   assign o_window_col     = '0;
   assign o_output_row_cnt = '0;
`endif

endmodule

// File: tb/tb_in_line_controller.sv
// Bench for in_line_controller: randomized pixel/ready traffic scored against a window model built from the image array.
module tb_in_line_controller;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n, i_start, pixel_in_valid, i_conv_ready;
   logic [7:0]        pixel_in;
   logic              o_done, pixel_ready, o_conv_valid, o_conv_row_start, o_conv_row_end;
   logic signed [7:0] win_got [25];
   logic [2:0]        o_read_base_ptr, o_write_ptr;
   logic [3:0]        o_current_state;
   logic [4:0]        o_window_col, o_output_row_cnt;

   in_line_controller dut (
      .clk(clk), .reset_n(reset_n), .i_start(i_start), .o_done(o_done),
      .pixel_in_valid(pixel_in_valid), .pixel_in(pixel_in), .pixel_ready(pixel_ready),
      .o_conv_valid(o_conv_valid), .i_conv_ready(i_conv_ready),
      .o_conv_row_start(o_conv_row_start), .o_conv_row_end(o_conv_row_end),
      .window_0_0(win_got[0]),  .window_0_1(win_got[1]),  .window_0_2(win_got[2]),
      .window_0_3(win_got[3]),  .window_0_4(win_got[4]),
      .window_1_0(win_got[5]),  .window_1_1(win_got[6]),  .window_1_2(win_got[7]),
      .window_1_3(win_got[8]),  .window_1_4(win_got[9]),
      .window_2_0(win_got[10]), .window_2_1(win_got[11]), .window_2_2(win_got[12]),
      .window_2_3(win_got[13]), .window_2_4(win_got[14]),
      .window_3_0(win_got[15]), .window_3_1(win_got[16]), .window_3_2(win_got[17]),
      .window_3_3(win_got[18]), .window_3_4(win_got[19]),
      .window_4_0(win_got[20]), .window_4_1(win_got[21]), .window_4_2(win_got[22]),
      .window_4_3(win_got[23]), .window_4_4(win_got[24]),
      .o_read_base_ptr(o_read_base_ptr), .o_write_ptr(o_write_ptr),
      .o_current_state(o_current_state), .o_window_col(o_window_col),
      .o_output_row_cnt(o_output_row_cnt)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] img [1024];

   // Results of the most recent frame, inspected by the scenario tasks.
   logic [7:0] first_win [25];
   logic [7:0] second_center;
   int         frame_k, frame_valid_cycles, frame_rs, frame_re;

   function automatic logic [7:0] all_out_or();
      logic [7:0] acc;
      acc = {o_done, pixel_ready, o_conv_valid, o_conv_row_start, o_conv_row_end, 3'b000};
      for (int i = 0; i < 25; i++) acc |= win_got[i];
      acc |= {5'd0, o_read_base_ptr} | {5'd0, o_write_ptr} | {4'd0, o_current_state}
           | {3'd0, o_window_col} | {3'd0, o_output_row_cnt};
      return acc;
   endfunction

   task automatic build_spec_img();
      for (int i = 0; i < 1024; i++) img[i] = 8'(i % 256);
      for (int k = 0; k < 32; k++) img[33*k] = 8'hEE;
      img[31] = 8'hBB; img[992] = 8'hCC; img[1023] = 8'hDD;
   endtask

   task automatic build_rand_img();
      for (int i = 0; i < 1024; i++) img[i] = 8'($urandom_range(255));
   endtask

   // Streams one frame. hold_px/stall_win < 0 disable those disturbances; abort_win >= 0 returns early.
   task automatic run_frame(input int vpct, input int rpct, input int stall_win,
                            input int hold_px, input int hold_cyc, input int abort_win);
      int pix, k, cyc, hold_cnt, stall_cnt, n160, row, col, bad_i;
      bit first_seen, hold_checked, holding;
      logic [7:0] exp_v;
      pix = 0; k = 0; cyc = 0; hold_cnt = 0; stall_cnt = 0; n160 = -1;
      first_seen = 0; hold_checked = 0;
      frame_valid_cycles = 0; frame_rs = 0; frame_re = 0;
      @(posedge clk); #1; i_start = 1'b1;
      @(posedge clk); #1; i_start = 1'b0;
      while (k < 784 && cyc < 20000) begin
         holding = (hold_px >= 0) && (pix == hold_px) && (hold_cnt < hold_cyc);
         if (holding) hold_cnt++;
         pixel_in_valid = !holding && (pix < 1024) && ($urandom_range(99) < vpct);
         pixel_in       = (pix < 1024) ? img[pix] : 8'h00;
         if (stall_win >= 0 && k == stall_win && stall_cnt < 10) begin
            i_conv_ready = 1'b0;
            stall_cnt++;
         end else begin
            i_conv_ready = ($urandom_range(99) < rpct);
         end
         @(negedge clk);
         cyc++;
         if (o_conv_valid) begin
            frame_valid_cycles++;
            row = k / 28; col = k % 28;
            bad_i = -1;
            for (int i = 0; i < 25; i++) begin
               exp_v = img[(row + i/5)*32 + col + i%5];
               if (bad_i < 0 && win_got[i] !== exp_v) bad_i = i;
            end
            checks++;
            if (bad_i >= 0) begin
               errors++;
               $display("FAIL window k=%0d tap=%0d got=%h exp=%h", k, bad_i, win_got[bad_i],
                        img[(row + bad_i/5)*32 + col + bad_i%5]);
            end
            checks++;
            if (o_conv_row_start !== (col == 0) || o_conv_row_end !== (col == 27)) begin
               errors++;
               $display("FAIL row_flags k=%0d got start=%b end=%b exp col=%0d", k,
                        o_conv_row_start, o_conv_row_end, col);
            end
            checks++;
`ifdef INLC_DEBUG_EN
            if (o_window_col !== 5'(col) || o_output_row_cnt !== 5'(row) ||
                o_read_base_ptr !== 3'(row % 6) || o_current_state !== 4'd2) begin
`else
            if ({o_window_col, o_output_row_cnt, o_read_base_ptr, o_current_state} !== 17'd0) begin
`endif
               errors++;
               $display("FAIL debug k=%0d got col=%0d row=%0d base=%0d st=%0d exp col=%0d row=%0d",
                        k, o_window_col, o_output_row_cnt, o_read_base_ptr, o_current_state, col, row);
            end
            if (!first_seen) begin
               first_seen = 1;
               checks++;
               if (cyc - n160 != 2) begin
                  errors++;
                  $display("FAIL first_latency got=%0d cycles exp=2", cyc - n160);
               end
            end
         end
         if (hold_px >= 0 && !hold_checked && hold_cnt >= hold_cyc) begin
            hold_checked = 1;
            checks++;
            if (pixel_ready !== 1'b1 || o_conv_valid !== 1'b0 ||
                k != ((hold_px/32 >= 5) ? (hold_px/32 - 4)*28 : 0)) begin
               errors++;
               $display("FAIL withhold got ready=%b valid=%b windows=%0d exp ready=1 valid=0 windows=%0d",
                        pixel_ready, o_conv_valid, k, (hold_px/32 >= 5) ? (hold_px/32 - 4)*28 : 0);
            end
         end
         if (pix == 1024) begin
            checks++;
            if (pixel_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_full got=%b exp=0", pixel_ready);
            end
         end
         if (pixel_in_valid && pixel_ready) begin
            if (pix == 159) n160 = cyc;
            pix++;
         end
         if (o_conv_valid && i_conv_ready) begin
            if (k == 0) for (int i = 0; i < 25; i++) first_win[i] = win_got[i];
            if (k == 1) second_center = win_got[12];
            if (o_conv_row_start) frame_rs++;
            if (o_conv_row_end) frame_re++;
            k++;
         end
         if (abort_win >= 0 && k >= abort_win) break;
         @(posedge clk); #1;
      end
      frame_k = k;
      if (abort_win >= 0 && k >= abort_win) return;
      @(posedge clk); #1;
      pixel_in_valid = 1'b0; i_conv_ready = 1'b0;
      checks++;
      if (cyc >= 20000) begin
         errors++;
         $display("FAIL frame_timeout got windows=%0d exp=784", k);
      end
      for (int i = 0; i < 20 && !o_done; i++) @(negedge clk);
      @(negedge clk);
      checks++;
      if (o_done !== 1'b1 || pixel_ready !== 1'b0 || o_conv_valid !== 1'b0 || pix != 1024) begin
         errors++;
         $display("FAIL done got done=%b ready=%b valid=%b pixels=%0d exp 1 0 0 1024",
                  o_done, pixel_ready, o_conv_valid, pix);
      end
`ifdef INLC_DEBUG_EN
      checks++;
      if (o_current_state !== 4'd4) begin
         errors++;
         $display("FAIL finish_state got=%0d exp=4", o_current_state);
      end
`endif
   endtask

   task automatic test_reset();
      reset_n = 1'b0; i_start = 1'b0; pixel_in_valid = 1'b0; pixel_in = '0; i_conv_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (all_out_or() !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs got or=%h exp=00", all_out_or());
      end
      reset_n = 1'b1;
      pixel_in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (pixel_ready !== 1'b0 || o_done !== 1'b0 || o_conv_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet got ready=%b done=%b valid=%b exp 0 0 0", pixel_ready, o_done, o_conv_valid);
      end
      pixel_in_valid = 1'b0;
   endtask

   task automatic test_full_frame();
      logic [7:0] exp_row0 [5];
      exp_row0[0] = 8'hEE; exp_row0[1] = 8'h01; exp_row0[2] = 8'h02; exp_row0[3] = 8'h03; exp_row0[4] = 8'h04;
      build_spec_img();
      run_frame(100, 100, -1, -1, 0, -1);
      checks++;
      if (frame_valid_cycles != 784) begin
         errors++;
         $display("FAIL valid_cycles got=%0d exp=784", frame_valid_cycles);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (first_win[i] !== exp_row0[i]) begin
            errors++;
            $display("FAIL win1_row0[%0d] got=%h exp=%h", i, first_win[i], exp_row0[i]);
         end
      end
      checks++;
      if (first_win[12] !== 8'hEE || second_center !== 8'h43) begin
         errors++;
         $display("FAIL centers got w1=%h w2=%h exp EE 43", first_win[12], second_center);
      end
   endtask

   task automatic test_random_flow();
      build_rand_img();
      run_frame(70, 60, -1, -1, 0, -1);
      checks++;
      if (frame_k != 784) begin
         errors++;
         $display("FAIL random_windows got=%0d exp=784", frame_k);
      end
   endtask

   task automatic test_stall();
      build_spec_img();
      run_frame(100, 100, 100, -1, 0, -1);
      checks++;
      if (frame_valid_cycles != 794 || frame_k != 784) begin
         errors++;
         $display("FAIL stall got valid_cycles=%0d windows=%0d exp 794 784", frame_valid_cycles, frame_k);
      end
   endtask

   task automatic test_row_boundaries();
      build_rand_img();
      run_frame(85, 80, -1, -1, 0, -1);
      checks++;
      if (frame_rs != 28 || frame_re != 28) begin
         errors++;
         $display("FAIL row_counts got start=%0d end=%0d exp 28 28", frame_rs, frame_re);
      end
   endtask

   task automatic test_withhold();
      build_spec_img();
      run_frame(100, 100, -1, 160, 60, -1);
      build_rand_img();
      run_frame(100, 100, -1, 191, 60, -1);
   endtask

   task automatic test_reset_mid_frame();
      build_rand_img();
      run_frame(90, 90, -1, -1, 0, 300);
      reset_n = 1'b0;
      #1;
      checks++;
      if (all_out_or() !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_outputs got or=%h exp=00", all_out_or());
      end
      pixel_in_valid = 1'b0; i_conv_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      build_spec_img();
      run_frame(100, 100, -1, -1, 0, -1);
      checks++;
      if (frame_valid_cycles != 784 || first_win[12] !== 8'hEE || second_center !== 8'h43) begin
         errors++;
         $display("FAIL restart got valid_cycles=%0d c1=%h c2=%h exp 784 EE 43",
                  frame_valid_cycles, first_win[12], second_center);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_random_flow();
      test_stall();
      test_row_boundaries();
      test_withhold();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
